// File: rtl/nap_keypad_pkg.sv
// Shared constants for the keypad matrix scanner: key codes, column strobes and frame-bit map.
package nap_keypad_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd15;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_SHARP = 4'd11;

  localparam int unsigned NUM_KEYS = 12;

  localparam logic [2:0] COL0_N = 3'b110;
  localparam logic [2:0] COL1_N = 3'b101;
  localparam logic [2:0] COL2_N = 3'b011;

  // Frame bit index is col*4 + row.
  function automatic logic [3:0] key_of_bit(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd4;
      4'd2:    code = 4'd7;
      4'd3:    code = KEY_STAR;
      4'd4:    code = 4'd2;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd8;
      4'd7:    code = 4'd0;
      4'd8:    code = 4'd3;
      4'd9:    code = 4'd6;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_SHARP;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] col_strobe(input logic [1:0] col);
    logic [2:0] strobe;
    case (col)
      2'd1:    strobe = COL1_N;
      2'd2:    strobe = COL2_N;
      default: strobe = COL0_N;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Commits a full-scan key frame once it has repeated unchanged for DEB_FRAMES further frames.
module keypad_frame_debounce #(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] frame,
  input  logic        frame_done,
  output logic [11:0] committed,
  output logic        commit
);

  localparam int unsigned CW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_FRAMES);

  logic [11:0]   prev_q;
  logic [11:0]   committed_q;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;
  logic          commit_q;
  logic          do_commit;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (frame_done) begin
      if (frame != prev_q) begin
        stable_cnt_d = '0;
      end else if (stable_cnt_q != CNT_MAX) begin
        stable_cnt_d = stable_cnt_q + 1'b1;
      end
    end
    do_commit = frame_done && (stable_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q       <= '0;
      committed_q  <= '0;
      stable_cnt_q <= '0;
      commit_q     <= 1'b0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      commit_q     <= do_commit;
      if (frame_done) prev_q <= frame;
      if (do_commit) committed_q <= frame;
    end
  end

  assign committed = committed_q;
  assign commit    = commit_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x3 membrane keypad scanner: column strobing, row synchronisation, frame debounce and decode.
module keypad_matrix_scan
  import nap_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] col_n,
  input  logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       sharp,
  output logic       star,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       multi_key
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [SW-1:0] slot_q;
  logic [1:0]    col_q, col_d;
  logic [2:0]    col_n_q;
  logic [11:0]   frame_q, frame_d;
  logic          slot_last, frame_done;

  logic [11:0] committed;
  logic        commit;

  logic [3:0] n_keys, dec_code;
  logic [9:0] dec_keypad;

  logic [9:0] keypad_q;
  logic       sharp_q, star_q, multi_q, valid_q;
  logic [3:0] code_q;

  assign slot_last  = (slot_q == SLOT_LAST);
  assign frame_done = slot_last && (col_q == 2'd2);

  always_comb begin
    col_d   = col_q;
    frame_d = frame_q;
    if (slot_last) begin
      col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      frame_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      slot_q     <= '0;
      col_q      <= 2'd0;
      col_n_q    <= COL0_N;
      frame_q    <= '0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      slot_q     <= slot_last ? '0 : slot_q + 1'b1;
      col_q      <= col_d;
      col_n_q    <= col_strobe(col_d);
      frame_q    <= frame_d;
    end
  end

  // frame_d carries column 2 on the completing sample, so the debouncer sees the whole frame.
  keypad_frame_debounce #(
    .DEB_FRAMES (DEB_FRAMES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .frame      (frame_d),
    .frame_done (frame_done),
    .committed  (committed),
    .commit     (commit)
  );

  // Ghost-key protection: anything other than exactly one pressed key decodes to KEY_NONE.
  always_comb begin
    n_keys   = '0;
    dec_code = KEY_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (committed[i]) begin
        n_keys   = n_keys + 4'd1;
        dec_code = key_of_bit(4'(i));
      end
    end
    if (n_keys != 4'd1) dec_code = KEY_NONE;
    dec_keypad = (dec_code < 4'd10) ? (10'd1 << dec_code) : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      keypad_q <= '0;
      sharp_q  <= 1'b0;
      star_q   <= 1'b0;
      multi_q  <= 1'b0;
      code_q   <= KEY_NONE;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (commit) begin
        keypad_q <= dec_keypad;
        sharp_q  <= (dec_code == KEY_SHARP);
        star_q   <= (dec_code == KEY_STAR);
        multi_q  <= (n_keys > 4'd1);
        code_q   <= dec_code;
        valid_q  <= (dec_code != KEY_NONE) && (dec_code != code_q);
      end
    end
  end

  assign col_n     = col_n_q;
  assign keypad    = keypad_q;
  assign sharp     = sharp_q;
  assign star      = star_q;
  assign multi_key = multi_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule
